// File: rtl/mu_sync_pkg.sv
// Shared constants and elaboration-time helpers for the mu_sync_filter synchroniser.
package mu_sync_pkg;

  localparam int STAGES_MIN = 2;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    for (int i = 0; i < 32; i++) begin
      if (rem > 0) begin
        result++;
        rem = rem >> 1;
      end
    end
    return result;
  endfunction

  // The filter counter must be at least one bit wide even when FILT_CYCLES is 1.
  function automatic int cnt_width(input int filt_cycles);
    return (clog2(filt_cycles) < 1) ? 1 : clog2(filt_cycles);
  endfunction

endpackage

// File: rtl/mu_sync_chan.sv
// One channel: register-only synchroniser chain, stability filter, edge pulses and
// the sticky change flag that exists only when MU_SYNC_FILTER_STATUS_EN is defined.
module mu_sync_chan
  import mu_sync_pkg::*;
#(
  parameter int   STAGES      = 2,
  parameter int   FILT_CYCLES = 4,
  parameter logic RST_BIT     = 1'b0
) (
  input  logic clk,
  input  logic reset_i,
  input  logic in_i,
  input  logic tick_i,
  input  logic clr_changed_i,
  output logic out_o,
  output logic rise_o,
  output logic fall_o,
  output logic changed_o
);

  localparam int              CNT_W   = cnt_width(FILT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_CYCLES - 1);

  (* srl_style = "register" *) logic [STAGES-1:0] sync_q;

  logic             sync_val;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  assign sync_val = sync_q[STAGES-1];

  // NOTE: every variable gets a default first so no path through this block infers a latch.
  always_comb begin
    cnt_d  = cnt_q;
    out_d  = out_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (sync_val == out_q) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == CNT_MAX) begin
        out_d  = sync_val;
        cnt_d  = '0;
        rise_d = sync_val;
        fall_d = ~sync_val;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      sync_q <= {STAGES{RST_BIT}};
      cnt_q  <= '0;
      out_q  <= RST_BIT;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], in_i};
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign out_o  = out_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

`ifdef MU_SYNC_FILTER_STATUS_EN
  logic changed_q, changed_d;

  // Set wins over clear so a pulse arriving together with a clear is never lost.
  assign changed_d = (changed_q & ~clr_changed_i) | rise_q | fall_q;

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= changed_d;
    end
  end

  assign changed_o = changed_q;
`else
  logic unused_clr_changed;

  assign unused_clr_changed = clr_changed_i;
  assign changed_o          = 1'b0;
`endif

endmodule

// File: rtl/mu_sync_filter.sv
// Multi-channel synchroniser and glitch filter; define MU_SYNC_FILTER_STATUS_EN for
// sticky per-channel change flags (the ports exist in both builds).
module mu_sync_filter
  import mu_sync_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               STAGES      = 2,
  parameter int               FILT_CYCLES = 4,
  parameter logic [WIDTH-1:0] RST_VAL     = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             tick,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] changed,
  input  logic [WIDTH-1:0] clr_changed
);

  if (STAGES < STAGES_MIN) begin : g_bad_stages
    $error("mu_sync_filter: STAGES must be at least %0d", STAGES_MIN);
  end

  if (FILT_CYCLES < 1) begin : g_bad_filt
    $error("mu_sync_filter: FILT_CYCLES must be at least 1");
  end

  if (WIDTH < 1) begin : g_bad_width
    $error("mu_sync_filter: WIDTH must be at least 1");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    mu_sync_chan #(
      .STAGES      (STAGES),
      .FILT_CYCLES (FILT_CYCLES),
      .RST_BIT     (RST_VAL[i])
    ) u_chan (
      .clk           (clk),
      .reset_i       (reset),
      .in_i          (in[i]),
      .tick_i        (tick),
      .clr_changed_i (clr_changed[i]),
      .out_o         (out[i]),
      .rise_o        (rise[i]),
      .fall_o        (fall[i]),
      .changed_o     (changed[i])
    );
  end

endmodule

// File: tb/tb_mu_sync_filter.sv
// Self-checking bench for mu_sync_filter: directed scenarios plus random stimulus
// compared every cycle against a delay-line / run-length reference model.
module tb_mu_sync_filter;

  localparam int               W       = 8;
  localparam int               STAGES  = 2;
  localparam int               FILT    = 4;
  localparam logic [W-1:0]     RST     = 8'hA5;
  localparam int               LAT     = STAGES + FILT;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] in_v;
  logic         tick;
  logic [W-1:0] clr;
  logic [W-1:0] out_v, rise_v, fall_v, chg_v;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic [W-1:0] hist[$];
  logic [W-1:0] out_m, rise_m, fall_m, chg_m;
  int           run_m[W];

  always #5 clk = ~clk;

  mu_sync_filter #(
    .WIDTH       (W),
    .STAGES      (STAGES),
    .FILT_CYCLES (FILT),
    .RST_VAL     (RST)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in          (in_v),
    .tick        (tick),
    .out         (out_v),
    .rise        (rise_v),
    .fall        (fall_v),
    .changed     (chg_v),
    .clr_changed (clr)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < STAGES; i++) hist.push_back(RST);
    out_m  = RST;
    rise_m = '0;
    fall_m = '0;
    chg_m  = '0;
    for (int i = 0; i < W; i++) run_m[i] = 0;
  endtask

  // The synchronised value is simply the input seen STAGES edges ago; the filter
  // counts consecutive tick-qualified disagreements and flips after FILT of them.
  task automatic model_edge();
    logic [W-1:0] sv;
    logic [W-1:0] new_rise, new_fall;
    sv       = hist[$];
    new_rise = '0;
    new_fall = '0;
    for (int i = 0; i < W; i++) begin
      if (sv[i] == out_m[i]) begin
        run_m[i] = 0;
      end else if (tick) begin
        run_m[i] = run_m[i] + 1;
        if (run_m[i] == FILT) begin
          run_m[i]    = 0;
          out_m[i]    = sv[i];
          new_rise[i] = sv[i];
          new_fall[i] = ~sv[i];
        end
      end
    end
`ifdef MU_SYNC_FILTER_STATUS_EN
    chg_m = (chg_m & ~clr) | rise_m | fall_m;
`endif
    rise_m = new_rise;
    fall_m = new_fall;
    hist.push_front(in_v);
    void'(hist.pop_back());
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_reset();
    else       model_edge();
    #1;
    check("out", out_v, out_m);
    check("rise", rise_v, rise_m);
    check("fall", fall_v, fall_m);
    check("changed", chg_v, chg_m);
  endtask

  initial begin
    int nt;
    bit seen;
    logic [W-1:0] flip;

    reset = 1'b1;
    in_v  = '0;
    tick  = 1'b1;
    clr   = '0;
    model_reset();

    // Reset holds RST_VAL with no pulses
    #1;
    check("rst_out_async", out_v, RST);
    repeat (3) step();
    check("rst_rise", rise_v, '0);
    check("rst_fall", fall_v, '0);

    // Release: in=0 propagates and fall pulses on the A5 bits exactly once
    reset = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      step();
      check("rel_out", out_v, (k == LAT) ? 8'h00 : RST);
      check("rel_fall", fall_v, (k == LAT) ? RST : 8'h00);
    end
    step();
    check("rel_fall_once", fall_v, '0);

    // Latency on channel 0 with tick tied high
    in_v[0] = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      step();
      check("lat_out0", {7'd0, out_v[0]}, {7'd0, (k == LAT)});
      check("lat_rise0", {7'd0, rise_v[0]}, {7'd0, (k == LAT)});
    end
    step();
    check("lat_rise0_once", {7'd0, rise_v[0]}, '0);

    // Glitch of FILT-1 cycles is rejected on channel 3
    in_v[3] = 1'b1;
    repeat (FILT - 1) step();
    in_v[3] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      check("glitch_out3", {7'd0, out_v[3]}, '0);
      check("glitch_rise3", {7'd0, rise_v[3]}, '0);
    end

    // A pulse of exactly FILT cycles gets through
    in_v[3] = 1'b1;
    repeat (FILT) step();
    in_v[3] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (rise_v[3]) seen = 1'b1;
    end
    check("pass_rise3_seen", {7'd0, seen}, 8'd1);

    // Tick gating: one tick in eight, out[1] flips at the FILT-th tick after arrival
    in_v[1] = 1'b1;
    nt = 0;
    for (int k = 1; k <= 60; k++) begin
      tick = (k % 8 == 0);
      step();
      if (k > STAGES && tick) nt++;
      check("tick_out1", {7'd0, out_v[1]}, {7'd0, (nt >= FILT)});
    end
    // 20-cycle low pulse spans too few ticks to pass
    in_v[1] = 1'b0;
    for (int k = 61; k <= 110; k++) begin
      if (k == 81) in_v[1] = 1'b1;
      tick = (k % 8 == 0);
      step();
      check("tick_reject_out1", {7'd0, out_v[1]}, 8'd1);
    end
    tick = 1'b1;
    repeat (2 * LAT) step();

    // Reset mid-count on channel 4: partial count discarded, full latency again
    in_v[4] = 1'b1;
    repeat (STAGES + 2) step();
    reset = 1'b1;
    #1;
    model_reset();
    check("midrst_out", out_v, RST);
    check("midrst_rise", rise_v, '0);
    check("midrst_fall", fall_v, '0);
    repeat (2) step();
    reset = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      step();
      check("midrst_out4", {7'd0, out_v[4]}, {7'd0, (k == LAT)});
      if (k < LAT) begin
        check("midrst_no_rise", rise_v, '0);
        check("midrst_no_fall", fall_v, '0);
      end
    end
    repeat (LAT) step();

`ifdef MU_SYNC_FILTER_STATUS_EN
    // Set wins over clear, then clear alone empties the flag
    clr     = '1;
    step();
    clr     = '0;
    in_v[5] = 1'b0;
    repeat (2 * LAT) step();
    clr     = '1;
    step();
    clr     = '0;
    in_v[5] = 1'b1;
    repeat (LAT - 1) step();
    clr[5] = 1'b1;
    step();
    check("stat_rise5", {7'd0, rise_v[5]}, 8'd1);
    step();
    check("stat_set_wins5", {7'd0, chg_v[5]}, 8'd1);
    step();
    check("stat_clear5", {7'd0, chg_v[5]}, '0);
    clr = '0;
`else
    clr = '1;
    step();
    check("stat_off", chg_v, '0);
    clr = '0;
`endif

    // Random stimulus against the model
    for (int k = 0; k < 400; k++) begin
      flip = '0;
      for (int b = 0; b < W; b++) flip[b] = ($urandom_range(0, 7) == 0);
      in_v = in_v ^ flip;
      tick = ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
